c1541_gcr: RTL

- Read/write data separator and GCR byte framer for the 1541 drive.
- Sits between the track buffer stage and the VIA/6502 side: consumes the track stage's flux pulses (its buff_dout) and drives its write inputs (buff_din, buff_we).
- Recovers the bit clock per speed zone and detects SYNC (10 consecutive 1s).
- Frames read bits into bytes and signals byte-ready on byte_n (SO). In write mode it serializes VIA bytes into flux pulses.

---
 rtl/c1541_gcr.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/c1541_gcr.sv
`default_nettype none
// ============================================================================
// Module   : c1541_gcr
// Brief    : 1541 data separator and GCR byte framer (read and write paths).
//            Define C1541_GCR_WPROT_EN to gate writes with wps_n.
// Revision : 1.0
// ============================================================================
module c1541_gcr #(
  parameter int BYTE_N_LEN     = 16,
  parameter int FLUX_PULSE_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mtr,
  input  logic       mode,
  input  logic       soe,
  input  logic       wps_n,
  input  logic [1:0] speed_zone,
  input  logic       flux_in,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       sync_n,
  output logic       byte_n,
  output logic       wr_flux,
  output logic       wr_en
);

  localparam logic [3:0] UE7_TOP = 4'hF;
  localparam logic [7:0] BN_LOAD = 8'(BYTE_N_LEN - 1);
  localparam logic [4:0] FL_LOAD = 5'(FLUX_PULSE_LEN - 1);

  logic       tick16;
  logic [3:0] ue7;
  logic [3:0] uf4;
  logic       flux_d;
  logic       mode_d;
  logic [9:0] shreg;
  logic [7:0] wr_sh;
  logic [2:0] bitcnt;
  logic       byte_go;
  logic       byte_rd;
  logic       flux_go;
  logic [7:0] bn_cnt;
  logic [4:0] fl_cnt;

  logic       carry;
  logic       flux_rise;
  logic       bit_clk;
  logic       rd_bit;
  logic [9:0] shreg_nxt;
  logic       sync_now;
  logic       wrap;
  logic       mode_chg;
  logic [7:0] wr_word;
  logic       wr_msb;
  logic       wr_allow;

`ifdef C1541_GCR_WPROT_EN
  assign wr_allow = wps_n;
`else
  logic unused_wps;
  assign unused_wps = wps_n;
  assign wr_allow   = 1'b1;
`endif

  // A flux edge re-phases the separator and suppresses any coincident bit clock.
  always_comb begin
    carry     = tick16 & (ue7 == UE7_TOP);
    flux_rise = mtr & mode & flux_in & ~flux_d;
    bit_clk   = mtr & carry & ~flux_rise & (uf4[1:0] == 2'b01);
    rd_bit    = (uf4[3:2] == 2'b00);
    shreg_nxt = {shreg[8:0], rd_bit};
    sync_now  = mode & (&shreg_nxt);
    wrap      = bit_clk & ~sync_now & (bitcnt == 3'd7);
    mode_chg  = mode ^ mode_d;
    wr_word   = (bitcnt == 3'd0) ? din : wr_sh;
    wr_msb    = wr_word[7];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick16 <= 1'b0;
      ue7    <= 4'd0;
      uf4    <= 4'd0;
      flux_d <= 1'b0;
      mode_d <= 1'b0;
      wr_en  <= 1'b0;
    end else begin
      tick16 <= ~tick16;
      flux_d <= flux_in;
      mode_d <= mode;
      wr_en  <= ~mode & mtr & wr_allow;
      if (!mtr) begin
        ue7 <= 4'd0;
        uf4 <= 4'd0;
      end else if (flux_rise) begin
        ue7 <= {2'b00, speed_zone};
        uf4 <= 4'd0;
      end else if (tick16) begin
        if (ue7 == UE7_TOP) begin
          ue7 <= {2'b00, speed_zone};
          uf4 <= uf4 + 4'd1;
        end else begin
          ue7 <= ue7 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= 10'd0;
      wr_sh   <= 8'd0;
      bitcnt  <= 3'd0;
      byte_go <= 1'b0;
      byte_rd <= 1'b0;
      flux_go <= 1'b0;
    end else if (!mtr || mode_chg) begin
      shreg   <= 10'd0;
      wr_sh   <= 8'd0;
      bitcnt  <= 3'd0;
      byte_go <= 1'b0;
      byte_rd <= 1'b0;
      flux_go <= 1'b0;
    end else begin
      byte_go <= wrap;
      byte_rd <= wrap & mode;
      flux_go <= bit_clk & ~mode & wr_msb;
      if (bit_clk) begin
        if (mode) begin
          shreg  <= shreg_nxt;
          bitcnt <= sync_now ? 3'd0 : bitcnt + 3'd1;
        end else begin
          wr_sh  <= {wr_word[6:0], 1'b0};
          bitcnt <= bitcnt + 3'd1;
        end
      end
    end
  end

  // sync_n looks at the settled shift register, so it trails the bit clock by one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_n <= 1'b1;
    end else if (!mtr || !mode) begin
      sync_n <= 1'b1;
    end else begin
      sync_n <= ~(&shreg);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout   <= 8'd0;
      byte_n <= 1'b1;
      bn_cnt <= 8'd0;
    end else begin
      if (byte_rd && mtr) begin
        dout <= shreg[7:0];
      end
      if (!mtr) begin
        byte_n <= 1'b1;
        bn_cnt <= 8'd0;
      end else if (byte_go && soe) begin
        byte_n <= 1'b0;
        bn_cnt <= BN_LOAD;
      end else if (!byte_n) begin
        if (bn_cnt == 8'd0) begin
          byte_n <= 1'b1;
        end else begin
          bn_cnt <= bn_cnt - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_flux <= 1'b0;
      fl_cnt  <= 5'd0;
    end else if (!mtr) begin
      wr_flux <= 1'b0;
      fl_cnt  <= 5'd0;
    end else if (flux_go && wr_allow) begin
      wr_flux <= 1'b1;
      fl_cnt  <= FL_LOAD;
    end else if (wr_flux) begin
      if (fl_cnt == 5'd0) begin
        wr_flux <= 1'b0;
      end else begin
        fl_cnt <= fl_cnt - 5'd1;
      end
    end
  end

endmodule
`default_nettype wire
